// File: rtl/mux_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_sel
// Brief    : N-channel registered select mux, explicit-select or round-robin.
// Revision : 1.0
// ============================================================================
module mux_rr_sel #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    localparam logic [SEL_W-1:0] c_rr_reset = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] r_out_data_q,  w_out_data_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [SEL_W-1:0] r_out_chan_q,  w_out_chan_d;
    logic [SEL_W-1:0] r_rr_ptr_q,    w_rr_ptr_d;

    logic             w_load;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_chosen;
    logic             w_chosen_ok;
    logic             w_chosen_valid;
    logic [WIDTH-1:0] w_chosen_data;
    logic             w_xfer;

    // in_ready is forced low while rst is high so nothing is accepted on the reset edge.
    assign w_load = !rst && (!r_out_valid_q || out_ready);

    // First valid channel scanning forward from the one after the last grant.
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(r_rr_ptr_q) + k) % CHANNELS;
            if (!w_rr_found && in_valid[idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        w_chosen       = mode ? w_rr_idx : sel;
        w_chosen_ok    = mode ? w_rr_found : (32'(sel) < CHANNELS);
        w_chosen_valid = 1'b0;
        w_chosen_data  = '0;
        in_ready       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_chosen_ok && (w_chosen == SEL_W'(i))) begin
                in_ready[i]    = w_load;
                w_chosen_valid = in_valid[i];
                w_chosen_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
        w_xfer = w_load && w_chosen_ok && w_chosen_valid;
    end

    always_comb begin
        w_out_data_d  = r_out_data_q;
        w_out_valid_d = r_out_valid_q;
        w_out_chan_d  = r_out_chan_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        if (w_xfer) begin
            w_out_data_d  = w_chosen_data;
            w_out_chan_d  = w_chosen;
            w_out_valid_d = 1'b1;
            if (mode) begin
                w_rr_ptr_d = w_chosen;
            end
        end else if (out_ready) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_out_chan_q  <= '0;
            r_rr_ptr_q    <= c_rr_reset;
        end else begin
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_chan_q  <= w_out_chan_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
        end
    end

    assign out_data  = r_out_data_q;
    assign out_valid = r_out_valid_q;
    assign out_chan  = r_out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_sel
// Brief    : Directed scoreboard bench for mux_rr_sel (4-channel and 3-channel).
// Revision : 1.0
// ============================================================================
module tb_mux_rr_sel;

    logic         clk = 1'b0;
    logic         rst;

    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_chan;

    logic         mode3;
    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_chan3;

    int           checks = 0;
    int           fails  = 0;
    logic [33:0]  sb[$];

    mux_rr_sel #(.WIDTH(32), .CHANNELS(4)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan)
    );

    mux_rr_sel #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_chan(out_chan3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check in_ready, retire the word being consumed, queue the
    // word expected to load, then check out_valid after the edge.
    task automatic step(input logic [3:0] exp_rdy, input bit push,
                        input logic [1:0] c, input logic exp_ov);
        logic [33:0] e;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", 32'(out_chan), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e[33:2]);
                chk("out_chan", 32'(out_chan), 32'(e[1:0]));
            end
        end
        if (push) sb.push_back({32'hA0 + 32'(c), c});
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mode3     = 1'b0;
        sel3      = 2'd0;
        in_data3  = {32'hB2, 32'hB1, 32'hB0};
        in_valid3 = 3'b000;
        out_ready3 = 1'b1;

        // Reset state, in_ready held low during reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        rst = 1'b0;

        // Explicit select 0..3
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step(4'b0001 << s, 1'b1, 2'(s), 1'b1);
        end

        // Backpressure holding A2, then same-edge reload with A0
        sel = 2'd2;
        step(4'b0100, 1'b1, 2'd2, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b0, 2'd0, 1'b1);
            chk("bp_hold_data", out_data, 32'hA2);
        end
        out_ready = 1'b1;
        sel = 2'd0;
        step(4'b0001, 1'b1, 2'd0, 1'b1);

        // Round-robin, all valid: pointer untouched by explicit mode, so starts at 0
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(4'b0001 << (k % 4), 1'b1, 2'(k % 4), 1'b1);
        end

        // Sparse round-robin: channels 1 and 3 only
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) step(4'b0010, 1'b1, 2'd1, 1'b1);
            else            step(4'b1000, 1'b1, 2'd3, 1'b1);
        end

        // Explicit detour leaves the pointer at 3, so next RR grant is 0
        mode = 1'b0;
        sel  = 2'd2;
        in_valid = 4'b1111;
        step(4'b0100, 1'b1, 2'd2, 1'b1);
        mode = 1'b1;
        step(4'b0001, 1'b1, 2'd0, 1'b1);

        // Drain: out_valid falls, data/chan hold
        in_valid = 4'b0000;
        step(4'b0000, 1'b0, 2'd0, 1'b0);
        chk("drain_hold_data", out_data, 32'hA0);
        chk("drain_hold_chan", 32'(out_chan), 32'h0);

        // Reset mid-stream in round-robin mode
        in_valid = 4'b1111;
        step(4'b0010, 1'b1, 2'd1, 1'b1);
        rst = 1'b1;
        out_ready = 1'b0;
        step(4'b0000, 1'b0, 2'd0, 1'b0);
        chk("midrst_out_data", out_data, 32'h0);
        chk("midrst_out_chan", 32'(out_chan), 32'h0);
        sb.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        step(4'b0001, 1'b1, 2'd0, 1'b1);
        in_valid = 4'b0000;
        step(4'b0000, 1'b0, 2'd0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // Three-channel instance: out-of-range select
        in_valid3 = 3'b111;
        sel3 = 2'd1;
        #1;
        chk("c3_in_ready_sel1", 32'(in_ready3), 32'h2);
        @(posedge clk);
        #1;
        chk("c3_out_valid", 32'(out_valid3), 32'h1);
        chk("c3_out_data", out_data3, 32'hB1);
        chk("c3_out_chan", 32'(out_chan3), 32'h1);
        sel3 = 2'd3;
        #1;
        chk("c3_in_ready_sel3", 32'(in_ready3), 32'h0);
        @(posedge clk);
        #1;
        chk("c3_out_valid_fall", 32'(out_valid3), 32'h0);
        chk("c3_hold_data", out_data3, 32'hB1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_sel.md
# mux_rr_sel

Parametrised N-channel, W-bit registered select/arbitration mux for the datapath and memory-bus side of the CPU. It generalises the fixed 4:1 operand mux to CHANNELS inputs with valid/ready handshaking and one output register stage. It has two run-time modes: explicit select, where a control-unit select picks the source, and round-robin arbitration among requesting channels. It sits between multiple producers (register-file ports, ALU result, memory read data, immediate paths) and a single registered consumer.

## Interface
- WIDTH, 32, data width per channel
- CHANNELS, 4, number of input channels (>= 2; need not be a power of 2)
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), width of select/channel-id fields

- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = explicit select, 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode = 0
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i = in_data[i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  registered; out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the word
- out_chan  output  SEL_W  registered index of the channel that supplied out_data

## Operation
- Reset, sampled on clk: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = CHANNELS-1. This gives channel 0 first priority after reset.
- load = !out_valid | out_ready. The output register can take a new word on this edge.
- Explicit mode (mode = 0):
  - chosen = sel; in_ready[i] = load & (i == sel).
  - If sel >= CHANNELS, no channel is chosen and in_ready = 0.
- Round-robin mode (mode = 1):
  - chosen = first i with in_valid[i] = 1, scanning rr_ptr+1, rr_ptr+2, … with wrap modulo CHANNELS.
  - in_ready[chosen] = load; all other bits are 0. When no input is valid, in_ready = 0.
- Transfer on channel c: in_valid[c] & in_ready[c] at a rising edge. Then out_data <= channel c data, out_chan <= c, out_valid <= 1.
  - In round-robin mode only, rr_ptr <= c.
  - rr_ptr is not updated in explicit mode.
- No transfer and out_ready = 1: out_valid <= 0. out_data and out_chan hold their last values.
- No transfer and out_ready = 0: all registers hold.
- At most one input transfer per cycle. in_ready never depends on in_valid of the same channel in explicit mode.
- mode and sel are sampled combinationally every cycle. Changing them never alters a word already held in the output register.
- Data is passed unmodified; no width conversion.

## Timing
- Latency: one cycle. A word accepted at edge k appears on out_data with out_valid = 1 after edge k.
- Throughput: one word per cycle while out_ready = 1 and a chosen input is valid.
- Backpressure: with out_valid = 1 and out_ready = 0, all in_ready = 0 and the output is held stable until accepted.
- Simultaneous out_ready and new transfer: the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Round-robin fairness: with all channels valid continuously and out_ready = 1, grants cycle 0,1,…,CHANNELS-1,0,…. Each channel waits at most CHANNELS-1 grants.
- Reset mid-operation: the held word is dropped (out_valid = 0) and rr_ptr returns to CHANNELS-1 on that edge. in_ready is 0 during the rst = 1 cycle.
- Mode switch from 1 to 0 and back: rr_ptr keeps its pre-switch value.

## Test plan
- Explicit select: CHANNELS = 4, WIDTH = 32. Inputs 0xA0, 0xA1, 0xA2, 0xA3, all valid, out_ready = 1, sel stepping 0→3. Required: out_data = 0xA0…0xA3 and out_chan = 0…3, each one cycle after its sel; in_ready one-hot matches sel.
- Round-robin: mode = 1, all four channels valid for 8 cycles, out_ready = 1. Required: out_chan sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Sparse round-robin: only channels 1 and 3 valid. Required: grants alternate 1,3,1,3. Channels 0 and 2 never see in_ready = 1.
- Backpressure: out_valid = 1 holding 0xA2, then out_ready = 0 for 3 cycles. Required: out_data stays 0xA2 and in_ready = 0000 for those cycles. When out_ready returns to 1, the next word loads on the same edge.
- Boundary: CHANNELS = 3 with sel = 3. Required: in_ready = 000 and out_valid falls to 0 after the held word is consumed.
- Reset mid-stream: assert rst while out_valid = 1 in round-robin mode. Required: after the edge, out_valid = 0, out_data = 0, out_chan = 0, and the first subsequent grant goes to channel 0.
